// File: rtl/c64_bus_arbiter_if.sv
// Bus bundle shared by the 6502 core, the video fetch unit and memory.
// The master modport is the arbiter's view; slave is the surrounding system.
interface c64_bus_arbiter_if;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_ce;
    logic        vid_req;
    logic        vid_steal;
    logic [15:0] vid_ab;
    logic [7:0]  vid_di;
    logic        vid_ack;
    logic        ba;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;

    modport master (
        input  cpu_ab, cpu_do, cpu_we, vid_req, vid_steal, vid_ab, mem_di,
        output cpu_di, cpu_ce, vid_di, vid_ack, ba, mem_ab, mem_do, mem_we
    );

    modport slave (
        output cpu_ab, cpu_do, cpu_we, vid_req, vid_steal, vid_ab, mem_di,
        input  cpu_di, cpu_ce, vid_di, vid_ack, ba, mem_ab, mem_do, mem_we
    );
endinterface

// File: rtl/c64_bus_arbiter.sv
// Two-phase bus arbiter between the 6502 core and video fetch with a BA/halt/steal FSM.
// Optional macro ARB_WRITE_SLIP_EN: CPU writes keep their slot during the BA warning.
module c64_bus_arbiter #(
    parameter int BA_LEAD = 3
) (
    input  logic               clk,
    input  logic               reset,
    c64_bus_arbiter_if.master  bus
);
    typedef enum logic [1:0] {RUN, WARN, HALT, STEAL} state_t;

    state_t      state, state_nx;
    logic        phase;
    logic [2:0]  cnt, cnt_nx;
    logic [7:0]  cpu_di_q;
    logic        grant_cpu, grant_vid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= 1'b0;
            state    <= RUN;
            cnt      <= '0;
            cpu_di_q <= '0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
            if (grant_cpu)
                cpu_di_q <= bus.mem_di;
        end
    end

    // Next state is only committed at the end of a CPU slot (phase 1).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (bus.vid_steal) begin
                    cnt_nx = 3'(BA_LEAD);
                    if (BA_LEAD == 0)
                        state_nx = STEAL;
                    else
                        state_nx = WARN;
                end
            end
            WARN, HALT: begin
                if (!bus.vid_steal) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else if (cnt == 3'd1) begin
                    state_nx = STEAL;
                end else begin
                    cnt_nx = cnt - 3'd1;
`ifdef ARB_WRITE_SLIP_EN
                    if (state == WARN && !bus.cpu_we)
                        state_nx = HALT;
`endif
                end
            end
            STEAL: begin
                if (!bus.vid_steal)
                    state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        if (phase) begin
            case (state)
                RUN:   grant_cpu = 1'b1;
`ifdef ARB_WRITE_SLIP_EN
                WARN:  grant_cpu = bus.cpu_we;
`else
                WARN:  grant_cpu = 1'b0;
`endif
                STEAL: grant_vid = 1'b1;
                default: ;
            endcase
        end

        bus.ba      = (state == RUN);
        bus.cpu_ce  = grant_cpu;
        bus.mem_ab  = grant_cpu ? bus.cpu_ab : bus.vid_ab;
        bus.mem_do  = bus.cpu_do;
        bus.mem_we  = grant_cpu & bus.cpu_we;
        bus.vid_ack = !reset && (phase ? (grant_vid & bus.vid_steal) : bus.vid_req);
        bus.vid_di  = bus.mem_di;
        bus.cpu_di  = grant_cpu ? bus.mem_di : cpu_di_q;
    end
endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Directed plus randomized check of c64_bus_arbiter against a cycle-count reference model.
module tb_c64_bus_arbiter;
    localparam int BA = 3;
    localparam int T  = (BA == 0) ? 1 : BA + 1;
`ifdef ARB_WRITE_SLIP_EN
    localparam bit SLIP = 1'b1;
`else
    localparam bit SLIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    c64_bus_arbiter_if bus ();

    c64_bus_arbiter #(.BA_LEAD(BA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] memf(input logic [15:0] a);
        if (a == 16'h0400) return 8'h20;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign bus.mem_di = memf(bus.mem_ab);

    int n_cmp = 0;
    int n_err = 0;

    // Model: p = phase, k = consecutive CPU-slot boundaries with vid_steal sampled high,
    // rd_seen = a CPU read occurred inside the current warning window.
    bit         p = 1'b0;
    int         k = 0;
    bit         rd_seen = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit gc, gv, warn;
        @(negedge clk);
        if (reset) begin
            check("rst_ba",     16'(bus.ba),     16'd1);
            check("rst_ce",     16'(bus.cpu_ce), 16'd0);
            check("rst_ack",    16'(bus.vid_ack),16'd0);
            check("rst_we",     16'(bus.mem_we), 16'd0);
            check("rst_ab",     bus.mem_ab,      bus.vid_ab);
            check("rst_cpu_di", 16'(bus.cpu_di), 16'h0000);
            gc = 1'b0;
        end else begin
            warn = (k > 0) && (k < T);
            gc   = p && ((k == 0) || (warn && SLIP && bus.cpu_we && !rd_seen));
            gv   = p && (k >= T);
            check("ba",     16'(bus.ba),     16'(k == 0));
            check("cpu_ce", 16'(bus.cpu_ce), 16'(gc));
            check("vid_ack",16'(bus.vid_ack),16'(p ? (gv & bus.vid_steal) : bus.vid_req));
            check("mem_we", 16'(bus.mem_we), 16'(gc & bus.cpu_we));
            if (gc) begin
                check("mem_ab_cpu", bus.mem_ab, bus.cpu_ab);
                check("mem_do",     16'(bus.mem_do), 16'(bus.cpu_do));
                check("cpu_di",     16'(bus.cpu_di), 16'(memf(bus.cpu_ab)));
            end else begin
                check("cpu_di_hold", 16'(bus.cpu_di), 16'(held));
            end
            if (!p || gv) begin
                check("mem_ab_vid", bus.mem_ab, bus.vid_ab);
                check("vid_di",     16'(bus.vid_di), 16'(memf(bus.vid_ab)));
            end
        end
        @(posedge clk);
        if (reset) begin
            p = 1'b0; k = 0; rd_seen = 1'b0; held = 8'h00;
        end else begin
            if (gc) held = memf(bus.cpu_ab);
            if (p) begin
                if (k > 0 && k < T && !bus.cpu_we) rd_seen = 1'b1;
                if (bus.vid_steal) begin
                    if (k < 100) k++;
                end else begin
                    k = 0;
                    rd_seen = 1'b0;
                end
            end
            p = !p;
        end
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bus.cpu_ab = 16'hC000; bus.cpu_do = 8'h00; bus.cpu_we = 1'b0;
        bus.vid_req = 1'b0; bus.vid_steal = 1'b0; bus.vid_ab = 16'h0000;

        // reset, then idle interleave
        cycles(2);
        reset = 1'b0;
        cycles(8);

        // video phase reads
        bus.vid_req = 1'b1; bus.vid_ab = 16'h0400;
        bus.cpu_ab = 16'hC001;
        cycles(6);
        bus.vid_req = 1'b0;
        cycles(1);

        // steal while CPU reads; then release from STEAL
        bus.vid_steal = 1'b1; bus.cpu_ab = 16'hC010;
        cycles(16);
        bus.vid_steal = 1'b0;
        cycles(6);

        // drop during the halt window
        bus.vid_steal = 1'b1;
        cycles(5);
        bus.vid_steal = 1'b0;
        cycles(6);

        // two writes then a read inside the warning window
        bus.vid_steal = 1'b1;
        bus.cpu_we = 1'b1; bus.cpu_do = 8'h55; bus.cpu_ab = 16'hD020;
        cycles(1);
        cycles(4);
        bus.cpu_we = 1'b0; bus.cpu_ab = 16'hC020;
        cycles(8);

        // reset mid-steal
        bus.vid_req = 1'b1;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        bus.vid_steal = 1'b0;
        cycles(8);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.cpu_ab  = 16'($urandom);
            bus.cpu_do  = 8'($urandom);
            bus.cpu_we  = 1'($urandom_range(0, 1));
            bus.vid_req = 1'($urandom_range(0, 1));
            bus.vid_ab  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.vid_steal = ~bus.vid_steal;
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
